kcpsm6_irq_ctrl: RTL and testbench
==================================

// Module: kcpsm6_irq_ctrl
// PURPOSE
// - Interrupt controller for the KCPSM6 core: it shares the single interrupt input among N_SRC requesters.
// - Each source's rising edges are latched as pending bits. The controller raises interrupt for the
//   highest-priority enabled source and holds it until interrupt_ack. It then waits for software to
//   clear that source through an output port.
// - Sits beside the port decode logic in the PicoBlaze top; its read data is OR'd into in_port.
// PARAMETERS
// - N_SRC        4      number of interrupt sources, 1..8; index 0 is the highest priority
// - PORT_PEND    8'h10  read: pending bits; write: W1C clear of pending bits
// - PORT_MASK    8'h11  read/write: enable mask, bit i enables source i
// - PORT_VEC     8'h12  read only: {in_service, 4'b0, cur_id[2:0]}
// PORTS
// - clk            in   1      system clock, all logic rising-edge
// - reset          in   1      async active-high reset
// - irq_src        in   N_SRC  interrupt requests, synchronous to clk, edge-sensitive
// - port_id        in   8      KCPSM6 port_id
// - out_port       in   8      KCPSM6 out_port
// - write_strobe   in   1      KCPSM6 write_strobe
// - read_strobe    in   1      KCPSM6 read_strobe (observed only, no side effects)
// - interrupt_ack  in   1      KCPSM6 interrupt_ack
// - interrupt      out  1      to KCPSM6 interrupt
// - in_port_irq    out  8      read data, registered; 0 when port_id is not one of ours
// - irq_busy       out  1      high whenever state != IDLE
// BEHAVIOUR
// - Reset (async): pending=0, mask=0, cur_id=0, state=IDLE, interrupt=0, in_port_irq=0, irq_busy=0.
//   - src_q (previous-sample register) resets to all ones, so a source held high through reset does not fire.
// - Edge detect: set_i = irq_src[i] & ~src_q[i]; src_q <= irq_src every cycle.
// - Pending update: pending[i] <= set_i | (pending[i] & ~clr_i).
//   - clr_i = write_strobe & port_id==PORT_PEND & out_port[i].
//   - Set and clear in the same cycle: set wins.
// - Mask: written on write_strobe & port_id==PORT_MASK; mask <= out_port[N_SRC-1:0].
// - active = pending & mask. Bits at and above N_SRC read 0 and ignore writes.
// - in_port_irq is registered from port_id each cycle (1-cycle latency, within the KCPSM6 2-cycle read window).
// - FSM:
//   - IDLE: if |active, then cur_id <= lowest set index of active, interrupt <= 1, go ASSERT.
//   - ASSERT: interrupt held at 1.
//     - interrupt_ack=1: interrupt <= 0, go SERVICE.
//     - Else if active[cur_id]=0 (masked or cleared before ack): interrupt <= 0, go IDLE (withdraw).
//     - If ack and withdrawal coincide, ack wins.
//   - SERVICE: interrupt=0; waits for pending[cur_id]=0, then goes to IDLE.
//     - Other sources keep latching but are not arbitrated until IDLE.
//     - If mask[cur_id] is cleared in SERVICE, stay until pending[cur_id] clears.
// - Re-arbitration: IDLE re-evaluates on the cycle after return.
//   - Minimum gap between interrupt pulses is 1 cycle at interrupt=0.
// - in_service = (state==SERVICE). irq_busy = (state!=IDLE).
// - interrupt_ack while in IDLE or SERVICE is ignored.
// - New edges on an already-pending source are absorbed; there is no counting.
// TESTING
// - Reset held with irq_src=4'b0001, then released -> pending stays 0, interrupt stays 0.
// - mask=4'hF, pulse irq_src[2] for 1 cycle -> pending=4'b0100, interrupt=1 two cycles after the edge.
//   - ack -> interrupt=0 and PORT_VEC reads 8'h82.
//   - W1C 8'h04 -> state IDLE.
// - Edges on sources 3 and 1 in the same cycle -> cur_id=1 served first.
//   - After W1C 8'h02 -> interrupt re-asserts with cur_id=3.
// - In ASSERT with cur_id=0 and no ack, write mask=0 -> interrupt drops next cycle, state IDLE, pending[0] still 1.
// - W1C of bit 2 in the same cycle as a new irq_src[2] edge -> pending[2] remains 1.
// - Assert reset asynchronously in SERVICE -> interrupt, in_port_irq, pending and mask all 0 immediately.

Source files
------------

// File: rtl/kcpsm6_irq_ctrl_if.sv
// KCPSM6 port bus and interrupt handshake, as seen by the interrupt controller.
// The master side is the processor; the slave side is the controller.
interface kcpsm6_irq_ctrl_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic       interrupt;
    logic [7:0] in_port_irq;

    modport master (
        output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
        input  interrupt, in_port_irq
    );

    modport slave (
        input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
        output interrupt, in_port_irq
    );
endinterface

// File: rtl/kcpsm6_irq_ctrl.sv
// Shares the single KCPSM6 interrupt input among N_SRC edge-triggered requesters.
// Source 0 has the highest priority, and a served source must be cleared by software.
module kcpsm6_irq_ctrl #(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] PORT_PEND = 8'h10,
    parameter logic [7:0] PORT_MASK = 8'h11,
    parameter logic [7:0] PORT_VEC  = 8'h12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src,
    kcpsm6_irq_ctrl_if.slave   bus,
    output logic               irq_busy
);

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] src_q, pending_q, mask_q;
    logic [N_SRC-1:0] set_v, clr_v, active;
    logic [2:0]       cur_id_q, sel_id;
    logic             int_q;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       pend_ext, mask_ext, active_ext;
    logic             pend_wr, mask_wr;

    assign pend_wr = bus.write_strobe && (bus.port_id == PORT_PEND);
    assign mask_wr = bus.write_strobe && (bus.port_id == PORT_MASK);
    assign set_v   = irq_src & ~src_q;
    assign clr_v   = pend_wr ? bus.out_port[N_SRC-1:0] : '0;
    assign active  = pending_q & mask_q;

    // src_q resets high so a source already asserted during reset is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q     <= '1;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            src_q     <= irq_src;
            pending_q <= set_v | (pending_q & ~clr_v);
            if (mask_wr)
                mask_q <= bus.out_port[N_SRC-1:0];
        end
    end

    // The vectors are widened to 8 bits so that cur_id can index them and they can feed the read mux.
    always_comb begin
        pend_ext   = '0;
        mask_ext   = '0;
        active_ext = '0;
        pend_ext[N_SRC-1:0]   = pending_q;
        mask_ext[N_SRC-1:0]   = mask_q;
        active_ext[N_SRC-1:0] = active;
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i])
                sel_id = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|active)
                    state_d = ASSERT;
            end
            ASSERT: begin
                if (bus.interrupt_ack)
                    state_d = SERVICE;
                else if (!active_ext[cur_id_q])
                    state_d = IDLE;
            end
            SERVICE: begin
                if (!pend_ext[cur_id_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            int_q    <= 1'b0;
            cur_id_q <= '0;
        end else begin
            state_q <= state_d;
            int_q   <= (state_d == ASSERT);
            if (state_q == IDLE && |active)
                cur_id_q <= sel_id;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (bus.port_id)
            PORT_PEND: rdata_d = pend_ext;
            PORT_MASK: rdata_d = mask_ext;
            PORT_VEC:  rdata_d = {(state_q == SERVICE), 4'b0000, cur_id_q};
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata_q <= '0;
        else
            rdata_q <= rdata_d;
    end

    assign bus.interrupt   = int_q;
    assign bus.in_port_irq = rdata_q;
    assign irq_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_kcpsm6_irq_ctrl.sv
// Self-checking bench for kcpsm6_irq_ctrl: port reads go through a scoreboard queue,
// and interrupt and busy timing are checked inline in each scenario.
module tb_kcpsm6_irq_ctrl;

    localparam logic [7:0] PEND = 8'h10;
    localparam logic [7:0] MASK = 8'h11;
    localparam logic [7:0] VEC  = 8'h12;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic       irq_busy;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb_q[$];

    kcpsm6_irq_ctrl_if bus ();

    kcpsm6_irq_ctrl #(.N_SRC(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .bus      (bus),
        .irq_busy (irq_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_port(input logic [7:0] id, input logic [7:0] data);
        bus.port_id      = id;
        bus.out_port     = data;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
        bus.out_port     = 8'h00;
        bus.port_id      = 8'h00;
    endtask

    // The expected value is queued when the read is issued and popped when the data returns.
    task automatic read_port(input logic [7:0] id, input logic [7:0] expv,
                             output logic [7:0] got, output logic [7:0] want);
        sb_q.push_back(expv);
        bus.port_id     = id;
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        got = bus.in_port_irq;
        bus.port_id = 8'h00;
        if (sb_q.size() > 0) want = sb_q.pop_front();
        else want = 8'hxx;
    endtask

    task automatic test_reset;
        logic [7:0] got, want;
        reset = 1'b1;
        irq_src = 4'b0001;
        repeat (3) tick();
        checks++;
        if (bus.interrupt !== 1'b0 || irq_busy !== 1'b0 || bus.in_port_irq !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: int=%b busy=%b rd=%h, required 0 0 00",
                     bus.interrupt, irq_busy, bus.in_port_irq);
        end
        reset = 1'b0;
        read_port(MASK, 8'h00, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL reset_mask: got %h required %h", got, want); end
        read_port(VEC, 8'h00, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL reset_vec: got %h required %h", got, want); end
        write_port(MASK, 8'h0F);
        repeat (2) tick();
        read_port(PEND, 8'h00, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL held_src_pend: got %h required %h", got, want); end
        checks++;
        if (bus.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL held_src_int: got %b required 0", bus.interrupt); end
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_single;
        logic [7:0] got, want;
        irq_src = 4'b0100;
        tick();
        checks++;
        if (bus.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL single_early: int=%b required 0", bus.interrupt); end
        irq_src = 4'b0000;
        tick();
        checks++;
        if (bus.interrupt !== 1'b1 || irq_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_raise: int=%b busy=%b required 1 1", bus.interrupt, irq_busy);
        end
        read_port(PEND, 8'h04, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL single_pend: got %h required %h", got, want); end
        read_port(VEC, 8'h02, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL single_vec_assert: got %h required %h", got, want); end
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        checks++;
        if (bus.interrupt !== 1'b0 || irq_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ack: int=%b busy=%b required 0 1", bus.interrupt, irq_busy);
        end
        read_port(VEC, 8'h82, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL single_vec_service: got %h required %h", got, want); end
        write_port(PEND, 8'h04);
        checks++;
        if (irq_busy !== 1'b1) begin errors++; $display("[TB] FAIL single_clr_lag: busy=%b required 1", irq_busy); end
        tick();
        checks++;
        if (irq_busy !== 1'b0 || bus.interrupt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: busy=%b int=%b required 0 0", irq_busy, bus.interrupt);
        end
    endtask

    task automatic test_priority;
        logic [7:0] got, want;
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        tick();
        checks++;
        if (bus.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL prio_raise: int=%b required 1", bus.interrupt); end
        read_port(VEC, 8'h01, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL prio_first_id: got %h required %h", got, want); end
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        read_port(VEC, 8'h81, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL prio_service_vec: got %h required %h", got, want); end
        write_port(PEND, 8'h02);
        tick();
        checks++;
        if (bus.interrupt !== 1'b0 || irq_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_gap: int=%b busy=%b required 0 0", bus.interrupt, irq_busy);
        end
        tick();
        checks++;
        if (bus.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL prio_rearm: int=%b required 1", bus.interrupt); end
        read_port(VEC, 8'h03, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL prio_second_id: got %h required %h", got, want); end
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        write_port(PEND, 8'h08);
        tick();
        checks++;
        if (irq_busy !== 1'b0) begin errors++; $display("[TB] FAIL prio_done: busy=%b required 0", irq_busy); end
    endtask

    task automatic test_withdraw;
        logic [7:0] got, want;
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        checks++;
        if (bus.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL wd_raise: int=%b required 1", bus.interrupt); end
        write_port(MASK, 8'h00);
        checks++;
        if (bus.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL wd_hold: int=%b required 1", bus.interrupt); end
        tick();
        checks++;
        if (bus.interrupt !== 1'b0 || irq_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wd_drop: int=%b busy=%b required 0 0", bus.interrupt, irq_busy);
        end
        read_port(PEND, 8'h01, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL wd_pend_kept: got %h required %h", got, want); end
        write_port(PEND, 8'h01);
    endtask

    task automatic test_set_wins;
        logic [7:0] got, want;
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0100;
        write_port(PEND, 8'h04);
        irq_src = 4'b0000;
        read_port(PEND, 8'h04, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL set_wins: got %h required %h", got, want); end
        for (int i = 0; i < 2; i++) begin
            irq_src = 4'b0001;
            tick();
            irq_src = 4'b0000;
            tick();
        end
        write_port(PEND, 8'h05);
        read_port(PEND, 8'h00, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL no_counting: got %h required %h", got, want); end
        write_port(MASK, 8'hFF);
        read_port(MASK, 8'h0F, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL mask_width: got %h required %h", got, want); end
        read_port(8'h13, 8'h00, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL foreign_port: got %h required %h", got, want); end
    endtask

    task automatic test_reset_in_service;
        logic [7:0] got, want;
        irq_src = 4'b0010;
        tick();
        irq_src = 4'b0000;
        tick();
        bus.port_id = PEND;
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        checks++;
        if (irq_busy !== 1'b1 || bus.in_port_irq !== 8'h02) begin
            errors++;
            $display("[TB] FAIL pre_reset: busy=%b rd=%h required 1 02", irq_busy, bus.in_port_irq);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.interrupt !== 1'b0 || irq_busy !== 1'b0 || bus.in_port_irq !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset: int=%b busy=%b rd=%h required 0 0 00",
                     bus.interrupt, irq_busy, bus.in_port_irq);
        end
        tick();
        reset = 1'b0;
        read_port(PEND, 8'h00, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL reset_pend_clear: got %h required %h", got, want); end
        read_port(MASK, 8'h00, got, want);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL reset_mask_clear: got %h required %h", got, want); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.port_id       = 8'h00;
        bus.out_port      = 8'h00;
        bus.write_strobe  = 1'b0;
        bus.read_strobe   = 1'b0;
        bus.interrupt_ack = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_withdraw();
        test_set_wins();
        test_reset_in_service();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
